// File: rtl/cmd_pkg.sv
// Shared opcode, channel and FSM-state definitions for the command dispatcher.
package cmd_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] OP_SWAP      = 8'd1;
    localparam logic [7:0] OP_CLEAR     = 8'd2;
    localparam logic [7:0] OP_LOAD_VTX  = 8'd3;
    localparam logic [7:0] OP_LOAD_EDGE = 8'd5;
    localparam logic [7:0] OP_DRAW_TRI  = 8'd6;
    localparam logic [7:0] OP_STATUS    = 8'd8;
    localparam logic [7:0] OP_FENCE     = 8'hFF;

    localparam int unsigned CH_SWAP      = 0;
    localparam int unsigned CH_CLEAR     = 1;
    localparam int unsigned CH_LOAD_VTX  = 2;
    localparam int unsigned CH_LOAD_EDGE = 4;
    localparam int unsigned CH_DRAW_TRI  = 5;
    localparam int unsigned CH_STATUS    = 7;

endpackage

// File: rtl/vsync_lock.sv
// Vsync lock: set by a swap issue, cleared on the falling edge of vsync; set wins a tie.
module vsync_lock (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_vsync,
    input  logic i_set,
    output logic o_lock
);

    logic r_vs_d;
    logic r_lock;
    logic w_fall;

    assign w_fall = r_vs_d & ~i_vsync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vs_d <= 1'b0;
            r_lock <= 1'b0;
        end else begin
            r_vs_d <= i_vsync;
            if (i_set) begin
                r_lock <= 1'b1;
            end else if (w_fall) begin
                r_lock <= 1'b0;
            end
        end
    end

    assign o_lock = r_lock;

endmodule

// File: rtl/cmd_dispatch.sv
// Packet-FIFO to command-unit dispatcher: opcode routing, vsync lock, fence,
// unknown-opcode drop with error count and a stall watchdog.
module cmd_dispatch
    import cmd_pkg::*;
#(
    parameter int unsigned     N_CH           = 8,
    parameter int unsigned     SIZE           = 256,
    parameter int unsigned     OPCODE_BYTE    = 2,
    parameter logic [7:0]      FENCE_OP       = OP_FENCE,
    parameter logic [N_CH-1:0] LOCK_MASK      = 8'b0000_0001,
    parameter logic [N_CH-1:0] LOCK_WAIT_MASK = 8'b0000_0011,
    parameter logic [15:0]     STALL_CYC      = 16'd50000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fifo_empty,
    input  logic [8*SIZE-1:0] i_fifo_data,
    output logic              o_rd_en,
    input  logic              i_vsync,
    input  logic [N_CH-1:0]   i_ch_busy,
    output logic [N_CH-1:0]   o_ch_start,
    output logic [8*SIZE-1:0] o_pkt_q,
    output logic [N_CH-1:0]   o_busy_vec,
    output logic              o_lock,
    output logic [7:0]        o_err_cnt,
    output logic              o_stall
);

    localparam logic [N_CH-1:0] ONE_HOT0 = N_CH'(1);

    state_t            r_state;
    state_t            w_state_d;
    logic [N_CH-1:0]   r_sel;
    logic [8*SIZE-1:0] r_pkt_q;
    logic [7:0]        r_err_cnt;
    logic              r_stall;
    logic [15:0]       r_stall_cnt;

    logic [7:0]        w_op;
    logic              w_is_ch;
    logic              w_is_fence;
    logic [N_CH-1:0]   w_sel;
    logic [N_CH-1:0]   w_hold_mask;
    logic              w_elig;
    logic              w_pop;
    logic              w_lock;
    logic              w_lock_set;

    assign w_op       = i_fifo_data[8*OPCODE_BYTE +: 8];
    assign w_is_ch    = (w_op != 8'd0) && (32'(w_op) <= N_CH);
    assign w_is_fence = !w_is_ch && (w_op == FENCE_OP);
    assign w_sel      = w_is_ch ? (ONE_HOT0 << (w_op - 8'd1)) : '0;

    // A channel is held by its own busy, or by the lock if it is a lock or lock-wait channel.
    assign w_hold_mask = i_ch_busy | (w_lock ? (LOCK_WAIT_MASK | LOCK_MASK) : '0);

    always_comb begin
        w_elig = 1'b0;
        if (!i_fifo_empty) begin
            if (w_is_ch) begin
                w_elig = ~|(w_sel & w_hold_mask);
            end else if (w_is_fence) begin
                w_elig = (i_ch_busy == '0) && !w_lock;
            end else begin
                w_elig = 1'b1;
            end
        end
    end

    // Gated by reset so a held reset never pops a packet or emits a partial start.
    assign w_pop      = (r_state == S_IDLE) && w_elig && i_rst_n;
    assign w_lock_set = (r_state == S_ISSUE) && |(r_sel & LOCK_MASK);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            S_IDLE:  if (w_pop) w_state_d = w_is_ch ? S_ISSUE : S_GAP;
            S_ISSUE: w_state_d = S_GAP;
            S_GAP:   w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_pkt_q     <= '0;
            r_err_cnt   <= 8'd0;
            r_stall     <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state <= w_state_d;
            if (w_pop) begin
                r_pkt_q <= i_fifo_data;
                r_sel   <= w_sel;
                if (!w_is_ch && !w_is_fence && (r_err_cnt != 8'hFF)) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
            if (w_pop) begin
                r_stall_cnt <= 16'd0;
                r_stall     <= 1'b0;
            end else if (i_fifo_empty) begin
                r_stall_cnt <= 16'd0;
            end else if ((r_state == S_IDLE) && !w_elig) begin
                if (r_stall_cnt != STALL_CYC) r_stall_cnt <= r_stall_cnt + 16'd1;
                if (r_stall_cnt == STALL_CYC - 16'd1) r_stall <= 1'b1;
            end
        end
    end

    vsync_lock u_vsync_lock (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_vsync (i_vsync),
        .i_set   (w_lock_set),
        .o_lock  (w_lock)
    );

    assign o_rd_en    = w_pop;
    assign o_ch_start = ((r_state == S_ISSUE) && i_rst_n) ? r_sel : '0;
    assign o_pkt_q    = r_pkt_q;
    assign o_busy_vec = i_ch_busy | (w_lock ? LOCK_MASK : '0);
    assign o_lock     = w_lock;
    assign o_err_cnt  = r_err_cnt;
    assign o_stall    = r_stall;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch: vector table, scoreboard of expected
// start pulses, and hand-written lock / fence / watchdog / reset sequences.
module tb_cmd_dispatch;

    localparam int unsigned N_CH = 8;
    localparam int unsigned SIZE = 8;
    localparam int unsigned W    = 8 * SIZE;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_fifo_empty;
    logic [W-1:0]  i_fifo_data;
    logic          o_rd_en;
    logic          i_vsync;
    logic [7:0]    i_ch_busy;
    logic [7:0]    o_ch_start;
    logic [W-1:0]  o_pkt_q;
    logic [7:0]    o_busy_vec;
    logic          o_lock;
    logic [7:0]    o_err_cnt;
    logic          o_stall;

    cmd_dispatch #(
        .N_CH           (N_CH),
        .SIZE           (SIZE),
        .OPCODE_BYTE    (2),
        .FENCE_OP       (8'hFF),
        .LOCK_MASK      (8'b0000_0001),
        .LOCK_WAIT_MASK (8'b0000_0011),
        .STALL_CYC      (16'd16)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_data  (i_fifo_data),
        .o_rd_en      (o_rd_en),
        .i_vsync      (i_vsync),
        .i_ch_busy    (i_ch_busy),
        .o_ch_start   (o_ch_start),
        .o_pkt_q      (o_pkt_q),
        .o_busy_vec   (o_busy_vec),
        .o_lock       (o_lock),
        .o_err_cnt    (o_err_cnt),
        .o_stall      (o_stall)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [7:0]   start;
        logic [W-1:0] pkt;
    } exp_t;

    typedef struct {
        logic [7:0] op;
        logic [7:0] start;
        int         err_inc;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [W-1:0] mk(input logic [7:0] op);
        logic [W-1:0] p;
        p = {$urandom, $urandom};
        p[23:16] = op;
        return p;
    endfunction

    // Present a packet and wait (bounded) for its pop; returns just after the pop edge.
    task automatic send(input logic [W-1:0] pkt, input int budget);
        int w;
        w = 0;
        i_fifo_data  = pkt;
        i_fifo_empty = 1'b0;
        #1;
        while (!o_rd_en && w < budget) begin
            @(posedge i_clk); #1;
            w++;
        end
        chk("pop", {63'd0, o_rd_en}, 64'd1);
        @(posedge i_clk); #1;
        i_fifo_empty = 1'b1;
        i_fifo_data  = {$urandom, $urandom};
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
        end
    endtask

    // Scoreboard: every start pulse must match the oldest expected one.
    always @(negedge i_clk) begin
        if (o_ch_start != 8'd0) begin
            chk("start_onehot", {63'd0, $onehot(o_ch_start)}, 64'd1);
            if (sb.size() == 0) begin
                chk("unexpected_start", {56'd0, o_ch_start}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_start", {56'd0, o_ch_start}, {56'd0, e.start});
                chk("sb_pkt", o_pkt_q, e.pkt);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t         vecs[8];
        logic [W-1:0] p;
        logic [W-1:0] p2;
        int           exp_err;
        int           seen;

        vecs[0] = '{8'h03, 8'b0000_0100, 0};
        vecs[1] = '{8'h02, 8'b0000_0010, 0};
        vecs[2] = '{8'h08, 8'b1000_0000, 0};
        vecs[3] = '{8'h40, 8'b0000_0000, 1};
        vecs[4] = '{8'h05, 8'b0001_0000, 0};
        vecs[5] = '{8'h00, 8'b0000_0000, 1};
        vecs[6] = '{8'hFF, 8'b0000_0000, 0};
        vecs[7] = '{8'h07, 8'b0100_0000, 0};

        i_rst_n      = 1'b0;
        i_fifo_empty = 1'b1;
        i_fifo_data  = '0;
        i_vsync      = 1'b0;
        i_ch_busy    = 8'h5A;
        cycles(2);
        chk("rst_rd_en", {63'd0, o_rd_en}, 64'd0);
        chk("rst_start", {56'd0, o_ch_start}, 64'd0);
        chk("rst_pkt_q", o_pkt_q, 64'd0);
        chk("rst_lock", {63'd0, o_lock}, 64'd0);
        chk("rst_err", {56'd0, o_err_cnt}, 64'd0);
        chk("rst_stall", {63'd0, o_stall}, 64'd0);
        chk("rst_busy_vec", {56'd0, o_busy_vec}, 64'h5A);
        i_ch_busy = 8'h00;
        i_rst_n   = 1'b1;
        cycles(1);

        // Latency and throughput: rd_en at t, start at t+1, next rd_en at t+3.
        p  = mk(8'h03);
        p2 = mk(8'h02);
        sb.push_back('{8'b0000_0100, p});
        sb.push_back('{8'b0000_0010, p2});
        send(p, 0);
        chk("t1_start", {56'd0, o_ch_start}, 64'h04);
        chk("t1_pkt_q", o_pkt_q, p);
        i_fifo_data  = p2;
        i_fifo_empty = 1'b0;
        #1;
        chk("t1_no_pop_issue", {63'd0, o_rd_en}, 64'd0);
        cycles(1);
        chk("t1_no_pop_gap", {63'd0, o_rd_en}, 64'd0);
        chk("t1_pkt_held", o_pkt_q, p);
        cycles(1);
        chk("t1_pop_t3", {63'd0, o_rd_en}, 64'd1);
        cycles(1);
        i_fifo_empty = 1'b1;
        chk("t1_start2", {56'd0, o_ch_start}, 64'h02);

        exp_err = 0;
        for (int i = 0; i < 8; i++) begin
            p = mk(vecs[i].op);
            if (vecs[i].start != 8'd0) sb.push_back('{vecs[i].start, p});
            send(p, 10);
            chk("vec_start", {56'd0, o_ch_start}, {56'd0, vecs[i].start});
            exp_err += vecs[i].err_inc;
            chk("vec_err", {56'd0, o_err_cnt}, 64'(exp_err));
        end

        // Busy hold on channel 4.
        i_ch_busy = 8'h10;
        p = mk(8'h05);
        sb.push_back('{8'b0001_0000, p});
        i_fifo_data  = p;
        i_fifo_empty = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge i_clk); #1;
            if (o_rd_en) seen++;
        end
        chk("busy_hold", 64'(seen), 64'd0);
        i_ch_busy = 8'h00;
        #1;
        chk("busy_release_pop", {63'd0, o_rd_en}, 64'd1);
        cycles(1);
        i_fifo_empty = 1'b1;
        chk("busy_release_start", {56'd0, o_ch_start}, 64'h10);

        // Vsync lock: swap sets lock, clear channel held until vsync falls.
        cycles(2);
        p = mk(8'h01);
        sb.push_back('{8'b0000_0001, p});
        send(p, 10);
        chk("swap_start", {56'd0, o_ch_start}, 64'h01);
        cycles(1);
        chk("lock_set", {63'd0, o_lock}, 64'd1);
        chk("lock_busy_vec", {56'd0, o_busy_vec}, 64'h01);
        p = mk(8'h02);
        sb.push_back('{8'b0000_0010, p});
        i_fifo_data  = p;
        i_fifo_empty = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge i_clk); #1;
            if (o_rd_en) seen++;
        end
        chk("lock_hold", 64'(seen), 64'd0);
        i_vsync = 1'b1;
        cycles(1);
        i_vsync = 1'b0;
        #1;
        chk("lock_before_fall", {63'd0, o_lock}, 64'd1);
        chk("lock_no_pop", {63'd0, o_rd_en}, 64'd0);
        cycles(1);
        chk("lock_cleared", {63'd0, o_lock}, 64'd0);
        chk("lock_pop", {63'd0, o_rd_en}, 64'd1);
        cycles(1);
        i_fifo_empty = 1'b1;
        chk("lock_start2", {56'd0, o_ch_start}, 64'h02);

        // Unknown opcodes: dropped, counted, saturating.
        cycles(2);
        i_rst_n = 1'b0;
        cycles(1);
        i_rst_n = 1'b1;
        chk("err_after_rst", {56'd0, o_err_cnt}, 64'd0);
        for (int i = 0; i < 3; i++) send(mk(8'h40), 10);
        chk("err_three", {56'd0, o_err_cnt}, 64'd3);
        for (int i = 0; i < 260; i++) send(mk(8'(8'h40 + (i % 64))), 10);
        chk("err_saturate", {56'd0, o_err_cnt}, 64'd255);

        // Fence held by busy; watchdog after 16 held cycles; both released on pop.
        cycles(3);
        i_ch_busy    = 8'h10;
        i_fifo_data  = mk(8'hFF);
        i_fifo_empty = 1'b0;
        seen = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge i_clk); #1;
            if (o_rd_en) seen++;
            if (i == 15) chk("stall_not_yet", {63'd0, o_stall}, 64'd0);
        end
        chk("fence_hold", 64'(seen), 64'd0);
        chk("stall_set", {63'd0, o_stall}, 64'd1);
        i_ch_busy = 8'h00;
        #1;
        chk("fence_pop", {63'd0, o_rd_en}, 64'd1);
        cycles(1);
        i_fifo_empty = 1'b1;
        chk("stall_cleared", {63'd0, o_stall}, 64'd0);
        chk("fence_no_start", {56'd0, o_ch_start}, 64'd0);
        chk("fence_no_err", {56'd0, o_err_cnt}, 64'd255);

        // Reset during S_ISSUE of a swap: no pulse, no lock, counters cleared.
        cycles(3);
        send(mk(8'h01), 10);
        i_rst_n = 1'b0;
        #1;
        chk("rst_issue_no_start", {56'd0, o_ch_start}, 64'd0);
        cycles(1);
        chk("rst_issue_lock", {63'd0, o_lock}, 64'd0);
        chk("rst_issue_err", {56'd0, o_err_cnt}, 64'd0);
        chk("rst_issue_pkt", o_pkt_q, 64'd0);
        i_rst_n = 1'b1;
        p = mk(8'h03);
        sb.push_back('{8'b0000_0100, p});
        send(p, 0);
        chk("post_rst_start", {56'd0, o_ch_start}, 64'h04);

        cycles(3);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
